prach_unreshape: RTL and testbench

Inverse of the PRACH reshape stage: accepts blocks of `SIZE` samples delivered as two parallel sample lanes and re-serialises each block into one sample per clock in natural index order. It sits on the return side of the long-sequence PRACH path, where paired-lane data is converted back to a serial `dq` stream for downstream per-channel processing. It absorbs bursty input with a two-bank ping-pong buffer.

---
 rtl/prach_unreshape.sv | 270 +++++++++++++++++++++++++++
 tb/tb_prach_unreshape.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prach_unreshape.sv
//==============================================================================
// Module      : prach_unreshape
// Description : Paired-lane to serial re-serialiser for the long-sequence
//               PRACH return path. Blocks of SIZE samples arrive as two
//               lanes (x[k] on dp1, x[k+SIZE/2] on dp2). They are buffered
//               in a two-bank ping-pong store and replayed one sample per
//               clock in natural index order x[0..SIZE-1].
// Ports       : clk, rst_n (async, active low)
//               din_dp1/din_dp2/din_dv/din_chn : paired-lane input beats
//               sync_in  : frame sync, flushes all buffered/in-flight data
//               dout_dq/dout_dv/dout_chn       : serial output stream
//               sync_out : sync_in delayed one cycle
//               err_ovf  : sticky dropped-beat flag (PRACH_UNRESHAPE_OVF_EN)
// Options     : define PRACH_UNRESHAPE_OVF_EN to build the err_ovf port/logic
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module prach_unreshape #(
    parameter int SIZE = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] din_dp1,
    input  logic [15:0] din_dp2,
    input  logic        din_dv,
    input  logic [7:0]  din_chn,
    input  logic        sync_in,
    output logic [15:0] dout_dq,
    output logic        dout_dv,
    output logic [7:0]  dout_chn,
    output logic        sync_out
`ifdef PRACH_UNRESHAPE_OVF_EN
    ,
    output logic        err_ovf
`endif
);

    localparam int c_half = SIZE / 2;
    localparam int c_aw   = $clog2(c_half);
    localparam int c_nw   = c_aw + 1;

    localparam logic [c_aw-1:0] c_wk_last = c_aw'(c_half - 1);
    localparam logic [c_nw-1:0] c_n_last  = c_nw'(SIZE - 1);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_read = 1'b1;

    // Storage: [bank][address], lower half holds dp1, upper half dp2
    logic [15:0]      r_mem_lo [2][c_half];
    logic [15:0]      r_mem_hi [2][c_half];
    logic [1:0][7:0]  r_tag;
    logic [1:0]       r_full;
    logic [1:0]       w_full_nxt;

    // Write side
    logic [c_aw-1:0]  r_wk;
    logic             r_wb;
    logic             w_wr_acc;
    logic             w_wr_last;

    // Read side FSM
    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [c_nw-1:0]  r_n;
    logic [c_nw-1:0]  w_n_nxt;
    logic             r_rb;
    logic             w_rb_nxt;
    logic             w_rd_en;
    logic             w_rd_done;

    // Read pipeline stage (RAM output register)
    logic [15:0]      r_rd_data;
    logic [7:0]       r_rd_chn;
    logic             r_rd_v;

    //--------------------------------------------------------------------------
    // Write side. A beat is accepted only into a bank that is not full; a
    // beat coincident with sync_in is discarded.
    //--------------------------------------------------------------------------
    assign w_wr_acc  = din_dv && !r_full[r_wb] && !sync_in;
    assign w_wr_last = w_wr_acc && (r_wk == c_wk_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wk  <= '0;
            r_wb  <= 1'b0;
            r_tag <= '0;
        end else if (sync_in) begin
            r_wk  <= '0;
            r_wb  <= 1'b0;
        end else if (w_wr_acc) begin
            if (r_wk == '0) begin
                r_tag[r_wb] <= din_chn;
            end
            if (w_wr_last) begin
                r_wk <= '0;
                r_wb <= ~r_wb;
            end else begin
                r_wk <= r_wk + 1'b1;
            end
        end
    end

    // Set on the last write, clear on the last read. These never target the
    // same bank in one cycle: a write needs full=0, a read needs full=1.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_last) begin
            w_full_nxt[r_wb] = 1'b1;
        end
        if (w_rd_done) begin
            w_full_nxt[r_rb] = 1'b0;
        end
        if (sync_in) begin
            w_full_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= '0;
        end else begin
            r_full <= w_full_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Read FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_n     <= '0;
            r_rb    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_n     <= w_n_nxt;
            r_rb    <= w_rb_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Read FSM: next state. At the last sample the reader moves straight on
    // to the other bank if it is already full, so back-to-back blocks are
    // emitted without a bubble.
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_n_nxt     = r_n;
        w_rb_nxt    = r_rb;
        if (sync_in) begin
            w_state_nxt = c_st_idle;
            w_n_nxt     = '0;
            w_rb_nxt    = 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (r_full[r_rb]) begin
                        w_state_nxt = c_st_read;
                        w_n_nxt     = '0;
                    end
                end
                c_st_read: begin
                    if (r_n == c_n_last) begin
                        w_rb_nxt = ~r_rb;
                        w_n_nxt  = '0;
                        if (r_full[~r_rb]) begin
                            w_state_nxt = c_st_read;
                        end else begin
                            w_state_nxt = c_st_idle;
                        end
                    end else begin
                        w_n_nxt = r_n + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_st_idle;
                    w_n_nxt     = '0;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Read FSM: outputs
    //--------------------------------------------------------------------------
    always_comb begin
        w_rd_en   = 1'b0;
        w_rd_done = 1'b0;
        if (r_state == c_st_read) begin
            w_rd_en   = 1'b1;
            w_rd_done = (r_n == c_n_last);
        end
    end

    //--------------------------------------------------------------------------
    // Buffer RAM: write port and registered read port. The MSB of n picks the
    // half, the remaining bits address within it.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem_lo[r_wb][r_wk] <= din_dp1;
            r_mem_hi[r_wb][r_wk] <= din_dp2;
        end
        if (w_rd_en) begin
            if (r_n[c_nw-1]) begin
                r_rd_data <= r_mem_hi[r_rb][r_n[c_aw-1:0]];
            end else begin
                r_rd_data <= r_mem_lo[r_rb][r_n[c_aw-1:0]];
            end
        end
    end

    // Valid/tag travel alongside the RAM read; sync squashes the stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_v   <= 1'b0;
            r_rd_chn <= '0;
        end else begin
            r_rd_v <= w_rd_en && !sync_in;
            if (w_rd_en) begin
                r_rd_chn <= r_tag[r_rb];
            end
        end
    end

    //--------------------------------------------------------------------------
    // Output stage. Data and tag update only on valid samples so dout_chn is
    // stable over a whole block.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_dq  <= '0;
            dout_dv  <= 1'b0;
            dout_chn <= '0;
            sync_out <= 1'b0;
        end else begin
            sync_out <= sync_in;
            if (sync_in) begin
                dout_dv <= 1'b0;
            end else begin
                dout_dv <= r_rd_v;
                if (r_rd_v) begin
                    dout_dq  <= r_rd_data;
                    dout_chn <= r_rd_chn;
                end
            end
        end
    end

`ifdef PRACH_UNRESHAPE_OVF_EN
    // A beat offered to a full bank is a dropped beat
    logic w_ovf;
    assign w_ovf = din_dv && r_full[r_wb] && !sync_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf <= 1'b0;
        end else if (sync_in) begin
            err_ovf <= 1'b0;
        end else if (w_ovf) begin
            err_ovf <= 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_prach_unreshape.sv
//==============================================================================
// Module      : tb_prach_unreshape
// Description : Directed self-checking bench for prach_unreshape (SIZE=128).
//               Output samples are captured with their cycle stamps and
//               compared against hand-computed sequences.
// Options     : define PRACH_UNRESHAPE_OVF_EN to also check err_ovf
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_prach_unreshape;

    localparam int SIZE = 128;
    localparam int HALF = SIZE / 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din_dp1;
    logic [15:0] din_dp2;
    logic        din_dv;
    logic [7:0]  din_chn;
    logic        sync_in;
    logic [15:0] dout_dq;
    logic        dout_dv;
    logic [7:0]  dout_chn;
    logic        sync_out;
`ifdef PRACH_UNRESHAPE_OVF_EN
    logic        err_ovf;
`endif

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;
    int last_edge = 0;

    logic [15:0] cap_dq  [$];
    logic [7:0]  cap_chn [$];
    int          cap_cyc [$];

    prach_unreshape #(.SIZE(SIZE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din_dp1  (din_dp1),
        .din_dp2  (din_dp2),
        .din_dv   (din_dv),
        .din_chn  (din_chn),
        .sync_in  (sync_in),
        .dout_dq  (dout_dq),
        .dout_dv  (dout_dv),
        .dout_chn (dout_chn),
        .sync_out (sync_out)
`ifdef PRACH_UNRESHAPE_OVF_EN
        ,
        .err_ovf  (err_ovf)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every valid output sample away from the active edge
    always @(negedge clk) begin
        if (dout_dv === 1'b1) begin
            cap_dq.push_back(dout_dq);
            cap_chn.push_back(dout_chn);
            cap_cyc.push_back(cyc);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_cap();
        cap_dq.delete();
        cap_chn.delete();
        cap_cyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] d1, input logic [15:0] d2, input logic [7:0] chn);
        din_dp1 = d1;
        din_dp2 = d2;
        din_chn = chn;
        din_dv  = 1'b1;
        @(posedge clk);
        #1;
        din_dv    = 1'b0;
        last_edge = cyc;
    endtask

    // Block whose natural-order samples are base, base+1, ..., base+SIZE-1.
    // The tag switches to tag_late from beat late_k onward.
    task automatic send_block(input logic [7:0] tag, input logic [7:0] tag_late, input int late_k,
                              input logic [15:0] base, input int gap);
        logic [15:0] lo;
        logic [15:0] hi;
        for (int k = 0; k < HALF; k++) begin
            lo = base + 16'(k);
            hi = base + 16'(k + HALF);
            beat(lo, hi, (k < late_k) ? tag : tag_late);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic wait_cap(input string tag, input int count, input int budget);
        int w;
        w = 0;
        while (cap_dq.size() < count && w < budget) begin
            @(posedge clk);
            w++;
        end
        #1;
        check_val(tag, cap_dq.size(), count);
    endtask

    task automatic poll_cap(input string tag, input int count, input int budget);
        int w;
        w = 0;
        while (cap_dq.size() < count && w < budget) begin
            @(negedge clk);
            #1;
            w++;
        end
        check_val(tag, cap_dq.size(), count);
    endtask

    task automatic check_block(input string tag, input int start, input logic [7:0] chn,
                               input logic [15:0] base);
        logic [15:0] e;
        if (cap_dq.size() < start + SIZE) begin
            check_val({tag, "_short"}, cap_dq.size(), start + SIZE);
            return;
        end
        for (int n = 0; n < SIZE; n++) begin
            e = base + 16'(n);
            check_val({tag, "_dq"}, 32'(cap_dq[start+n]), 32'(e));
            check_val({tag, "_chn"}, 32'(cap_chn[start+n]), 32'(chn));
            if (n > 0) check_val({tag, "_gap"}, cap_cyc[start+n], cap_cyc[start+n-1] + 1);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        din_dp1 = '0;
        din_dp2 = '0;
        din_dv  = 1'b0;
        din_chn = '0;
        sync_in = 1'b0;
        idle(3);

        // Reset state
        check_val("rst_dq", 32'(dout_dq), 0);
        check_val("rst_dv", 32'(dout_dv), 0);
        check_val("rst_chn", 32'(dout_chn), 0);
        check_val("rst_sync", 32'(sync_out), 0);
`ifdef PRACH_UNRESHAPE_OVF_EN
        check_val("rst_ovf", 32'(err_ovf), 0);
`endif
        rst_n = 1'b1;
        idle(2);

        // Single block at 1 beat / 2 cycles, latency and length
        clear_cap();
        send_block(8'd5, 8'd5, HALF, 16'd0, 1);
        begin
            int e_last;
            e_last = last_edge;
            wait_cap("t1_wait", SIZE, 400);
            if (cap_cyc.size() > 0) check_val("t1_lat", cap_cyc[0], e_last + 3);
        end
        check_block("t1", 0, 8'd5, 16'd0);
        idle(10);
        check_val("t1_len", cap_dq.size(), SIZE);

        // Three blocks at full rate: 1 and 2 back-to-back, 3 dropped
        clear_cap();
        send_block(8'd1, 8'd1, HALF, 16'd1000, 0);
        send_block(8'd2, 8'd2, HALF, 16'd2000, 0);
        send_block(8'd3, 8'd3, HALF, 16'd3000, 0);
`ifdef PRACH_UNRESHAPE_OVF_EN
        check_val("t2_ovf", 32'(err_ovf), 1);
`endif
        wait_cap("t2_wait", 2 * SIZE, 600);
        check_block("t2_b1", 0, 8'd1, 16'd1000);
        check_block("t2_b2", SIZE, 8'd2, 16'd2000);
        if (cap_cyc.size() > SIZE)
            check_val("t2_nobubble", cap_cyc[SIZE], cap_cyc[SIZE-1] + 1);
        idle(200);
        check_val("t2_drop", cap_dq.size(), 2 * SIZE);
        sync_in = 1'b1;
        idle(1);
        sync_in = 1'b0;
`ifdef PRACH_UNRESHAPE_OVF_EN
        check_val("t2_ovf_clr", 32'(err_ovf), 0);
`endif
        idle(2);

        // Ten blocks sustained at 1 beat / 2 cycles
        clear_cap();
        for (int b = 0; b < 10; b++) begin
            send_block(8'(20 + b), 8'(20 + b), HALF, 16'(10000 + b * SIZE), 1);
        end
        wait_cap("t3_wait", 10 * SIZE, 400);
        for (int b = 0; b < 10; b++) begin
            check_block("t3", b * SIZE, 8'(20 + b), 16'(10000 + b * SIZE));
        end
`ifdef PRACH_UNRESHAPE_OVF_EN
        check_val("t3_ovf", 32'(err_ovf), 0);
`endif

        // sync_in at output sample 40
        clear_cap();
        send_block(8'd8, 8'd8, HALF, 16'd20000, 1);
        poll_cap("t4_reach", 41, 400);
        sync_in = 1'b1;
        idle(1);
        sync_in = 1'b0;
        check_val("t4_dv_drop", 32'(dout_dv), 0);
        check_val("t4_sync_hi", 32'(sync_out), 1);
        idle(1);
        check_val("t4_sync_lo", 32'(sync_out), 0);
        idle(150);
        check_val("t4_len", cap_dq.size(), 41);
        if (cap_dq.size() > 40) check_val("t4_s40", 32'(cap_dq[40]), 20040);
        clear_cap();
        send_block(8'd11, 8'd11, HALF, 16'd30000, 0);
        wait_cap("t4_new_wait", SIZE, 400);
        check_block("t4_new", 0, 8'd11, 16'd30000);

        // Tag changed mid-block: only the beat-0 tag is used
        idle(10);
        clear_cap();
        send_block(8'd7, 8'd9, 10, 16'd40000, 1);
        wait_cap("t5_wait", SIZE, 400);
        check_block("t5", 0, 8'd7, 16'd40000);

        // Reset mid-readout
        idle(10);
        clear_cap();
        send_block(8'd12, 8'd12, HALF, 16'd50000, 1);
        poll_cap("t6_reach", 20, 400);
        rst_n = 1'b0;
        #1;
        check_val("t6_dq", 32'(dout_dq), 0);
        check_val("t6_dv", 32'(dout_dv), 0);
        check_val("t6_chn", 32'(dout_chn), 0);
        check_val("t6_sync", 32'(sync_out), 0);
        idle(3);
        check_val("t6_dv_hold", 32'(dout_dv), 0);
        check_val("t6_dq_hold", 32'(dout_dq), 0);
        rst_n = 1'b1;
        idle(2);
        clear_cap();
        send_block(8'd13, 8'd13, HALF, 16'd60000, 1);
        wait_cap("t6_new_wait", SIZE, 400);
        check_block("t6_new", 0, 8'd13, 16'd60000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
